// File: rtl/button_event_gen.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events held in a one-entry valid/ready slot.
// Define BUTTON_EVENT_AUTOREPEAT_EN to emit REPEAT events while the button stays held.
module button_event_gen #(
    parameter int unsigned C_CNT_BITS      = 26,
    parameter int unsigned C_LONG_CYCLES   = 50_000_000,
    parameter int unsigned C_REPEAT_CYCLES = 10_000_000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       SIGNAL_I,
    output logic       EVT_VALID,
    output logic [1:0] EVT_CODE,
    input  logic       EVT_READY,
    output logic       PRESSED,
    output logic       OVERFLOW,
    input  logic       OVF_CLR
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;

    localparam logic [C_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [C_CNT_BITS-1:0] CNT_ONE  = C_CNT_BITS'(1);
    localparam logic [C_CNT_BITS-1:0] LONG_TC  = C_CNT_BITS'(C_LONG_CYCLES - 1);

    // Terminal counts must be reachable without the counter wrapping.
    if (C_LONG_CYCLES < 2 || C_REPEAT_CYCLES < 2 ||
        (C_LONG_CYCLES >> C_CNT_BITS) != 0 ||
        (C_REPEAT_CYCLES >> C_CNT_BITS) != 0) begin : g_param_err
        $error("button_event_gen: bad hold-count parameters");
    end

    logic                  r_s_q;
    logic [1:0]            r_state;
    logic [C_CNT_BITS-1:0] r_cnt;
    logic                  r_evt_valid;
    logic [1:0]            r_evt_code;
    logic                  r_ovf;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_gen;
    logic [1:0]            w_code;
    logic [1:0]            w_nstate;
    logic [C_CNT_BITS-1:0] w_ncnt;
    logic                  w_accept;

    assign w_rise = SIGNAL_I & ~r_s_q;
    assign w_fall = ~SIGNAL_I & r_s_q;

    always_comb begin
        w_gen    = 1'b0;
        w_code   = EV_PRESS;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_ncnt = CNT_ZERO;
                if (w_rise) begin
                    w_nstate = ST_PRESS;
                    w_gen    = 1'b1;
                    w_code   = EV_PRESS;
                end
            end
            ST_PRESS: begin
                if (w_fall) begin
                    w_nstate = ST_IDLE;
                    w_ncnt   = CNT_ZERO;
                    w_gen    = 1'b1;
                    w_code   = EV_RELEASE;
                end else if (r_cnt == LONG_TC) begin
                    w_nstate = ST_HELD;
                    w_ncnt   = CNT_ZERO;
                    w_gen    = 1'b1;
                    w_code   = EV_LONG;
                end else begin
                    w_ncnt = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_nstate = ST_IDLE;
                    w_ncnt   = CNT_ZERO;
                    w_gen    = 1'b1;
                    w_code   = EV_RELEASE;
                end else begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
                    if (r_cnt == C_CNT_BITS'(C_REPEAT_CYCLES - 1)) begin
                        w_ncnt = CNT_ZERO;
                        w_gen  = 1'b1;
                        w_code = 2'd3;
                    end else begin
                        w_ncnt = r_cnt + CNT_ONE;
                    end
`else
                    w_ncnt = CNT_ZERO;
`endif
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_ncnt   = CNT_ZERO;
            end
        endcase
    end

    // A full slot only takes a new event if it is drained in the same cycle.
    assign w_accept = ~r_evt_valid | EVT_READY;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_s_q       <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_evt_valid <= 1'b0;
            r_evt_code  <= EV_PRESS;
            r_ovf       <= 1'b0;
        end else begin
            r_s_q   <= SIGNAL_I;
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (w_gen && w_accept) begin
                r_evt_valid <= 1'b1;
                r_evt_code  <= w_code;
            end else if (!w_gen && r_evt_valid && EVT_READY) begin
                r_evt_valid <= 1'b0;
            end
            if (w_gen && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (OVF_CLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign EVT_VALID = r_evt_valid;
    assign EVT_CODE  = r_evt_code;
    assign PRESSED   = (r_state != ST_IDLE);
    assign OVERFLOW  = r_ovf;

endmodule
